iob_responder: RTL
==================

IOB_RESPONDER -- requirements
Module: iob_responder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255: WAIT-state clocks before a self-generated bus error.
REQ-002 SHALL have port CLK  in  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port RES  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports BACT  in  1 (FSB cycle active); IOCS, IACS, IOPWCS  in  1 each (decoded selects); nWE  in  1 (FSB write, active-low).
REQ-005 SHALL have ports A  in  23  FSB address[23:1]; DIN  in  16  FSB write data; nUDS, nLDS  in  1 each  FSB byte strobes.
REQ-006 SHALL have ports FSB_ACK  out  1  one-clock cycle-termination pulse; BERR  out  1  error qualifier valid with FSB_ACK; DOUT  out  16  read data.
REQ-007 SHALL have ports IOA  out  23; IODOUT  out  16; IODIN  in  16; IOnAS, IOnUDS, IOnLDS, IORnW  out  1 each; IOnDTACK, IOnBERR  in  1 each (IOB clock domain).
REQ-008 SHALL have port BUSY  out  1  high whenever state is not IDLE or the posted buffer is full.

Function
REQ-009 A new request SHALL be accepted when BACT=1, (IOCS|IACS)=1, and the request has not yet been serviced; the serviced flag SHALL clear when BACT=0.
REQ-010 States SHALL be IDLE, SETUP, STROBE, WAIT, HOLD; every transition SHALL take exactly one clock edge.
REQ-011 IDLE->SETUP on an accepted request or on a full posted buffer; a full buffer SHALL be drained before a new request is serviced.
REQ-012 SETUP SHALL drive IOA, IORnW (=nWE), and IODOUT; all IOB strobes SHALL remain high.
REQ-013 STROBE SHALL assert IOnAS; on reads it SHALL also assert IOnUDS/IOnLDS from the latched nUDS/nLDS; on writes the byte strobes SHALL assert on entry to WAIT.
REQ-014 IOnDTACK and IOnBERR SHALL each pass through a 2-flop synchronizer before use.
REQ-015 WAIT->HOLD SHALL occur on a synchronized DTACK low, on a synchronized BERR low, or when the wait counter reaches TIMEOUT_CYC.
REQ-016 If DTACK and BERR are seen low on the same edge, BERR SHALL win.
REQ-017 On a read, DOUT SHALL capture IODIN at the WAIT->HOLD edge.
REQ-018 FSB_ACK SHALL pulse high for exactly the clock after the WAIT->HOLD edge, with BERR=1 on an IOB bus error or timeout.
REQ-019 FSB_ACK SHALL be suppressed if BACT=0 at that point (aborted FSB cycle); the IOB cycle SHALL still complete.
REQ-020 HOLD SHALL deassert IOnAS, IOnUDS, and IOnLDS, then go to IDLE; IORnW SHALL return to 1 in IDLE.
REQ-021 The wait counter SHALL be 8 bits, SHALL clear on WAIT entry, and SHALL saturate rather than wrap.
REQ-022 IACS cycles SHALL run as reads with IOA=A.

Reset
REQ-023 RES=1 SHALL immediately force: IOnAS, IOnUDS, IOnLDS, IORnW=1; FSB_ACK, BERR, BUSY=0; DOUT, IOA, IODOUT=0; state IDLE; wait counter 0; synchronizers 1; posted buffer empty.
REQ-024 Reset mid-cycle SHALL abort the IOB cycle with strobes high; any posted write SHALL be discarded.

Configuration
REQ-025 With macro IOB_POSTED_WRITE_EN defined, a write with IOPWCS=1 and an empty buffer SHALL latch A, DIN, and byte strobes into a one-entry buffer, pulse FSB_ACK (BERR=0) on the next clock, and drain later via SETUP.
REQ-026 With IOB_POSTED_WRITE_EN defined, an IOB bus error on a drained posted write SHALL be dropped silently, with no FSB_ACK.
REQ-027 Without IOB_POSTED_WRITE_EN, all writes SHALL be non-posted, and the buffer logic SHALL be absent.

Structure
REQ-028 A shared package SHALL hold the state enumeration, the TIMEOUT_CYC default, and the posted-buffer entry type (addr 23, data 16, strobes 2).
REQ-029 The synchronizer SHALL be sub-module iob_sync2 (2-flop, reset value 1), instantiated twice.

Verification
REQ-030 Read with IOnDTACK held low: request at edge 0 -> IOnAS low from edge 2, FSB_ACK high for the clock after edge 4, DOUT=IODIN=16'hA55A.
REQ-031 Read with IOnDTACK never low: FSB_ACK=1, BERR=1 after 255 WAIT clocks; all strobes high at the next edge.
REQ-032 IOnDTACK and IOnBERR dropped on the same clock -> FSB_ACK=1 with BERR=1.
REQ-033 With IOB_POSTED_WRITE_EN: write with IOPWCS=1, A=23'h7FFF00, DIN=16'h1234 -> FSB_ACK the next clock; IOB write later shows IOA=23'h7FFF00, IODOUT=16'h1234.
REQ-034 With IOB_POSTED_WRITE_EN: second posted write while the buffer is full -> no FSB_ACK until the first IOB write reaches HOLD, BUSY=1 throughout.
REQ-035 RES asserted during WAIT -> strobes high and BUSY=0 with no clock edge; the posted write is not issued afterwards.

Source files
------------

// File: rtl/iob_responder_pkg.sv
// Shared types for the IOB responder: FSM states, posted-write buffer entry, timeout default.
package iob_responder_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StStrobe,
      StWait,
      StHold
   } state_e;

   localparam int unsigned TimeoutCycDefault = 255;

   typedef struct packed {
      logic [22:0] addr;
      logic [15:0] data;
      logic [1:0]  strb;  // {nUDS, nLDS}
   } pw_entry_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/iob_responder_if.sv
// FSB-side request/response and IOB-side bus signals of the IOB responder.
interface iob_responder_if;
   logic        BACT;
   logic        IOCS;
   logic        IACS;
   logic        IOPWCS;
   logic        nWE;
   logic [22:0] A;
   logic [15:0] DIN;
   logic        nUDS;
   logic        nLDS;
   logic        FSB_ACK;
   logic        BERR;
   logic [15:0] DOUT;
   logic [22:0] IOA;
   logic [15:0] IODOUT;
   logic [15:0] IODIN;
   logic        IOnAS;
   logic        IOnUDS;
   logic        IOnLDS;
   logic        IORnW;
   logic        IOnDTACK;
   logic        IOnBERR;
   logic        BUSY;

   modport slave (
      input  BACT, IOCS, IACS, IOPWCS, nWE, A, DIN, nUDS, nLDS, IODIN, IOnDTACK, IOnBERR,
      output FSB_ACK, BERR, DOUT, IOA, IODOUT, IOnAS, IOnUDS, IOnLDS, IORnW, BUSY
   );

   modport master (
      output BACT, IOCS, IACS, IOPWCS, nWE, A, DIN, nUDS, nLDS, IODIN, IOnDTACK, IOnBERR,
      input  FSB_ACK, BERR, DOUT, IOA, IODOUT, IOnAS, IOnUDS, IOnLDS, IORnW, BUSY
   );
endinterface

// File: rtl/iob_sync2.sv
// Two-flop synchronizer for active-low IOB inputs; resets to the inactive (high) level.
module iob_sync2 (
   input  logic CLK,
   input  logic RES,
   input  logic d,
   output logic q
);
   logic meta_q;

   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         meta_q <= 1'b1;
         q      <= 1'b1;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end
endmodule

// File: rtl/iob_responder.sv
// Bridges FSB cycles onto the asynchronous IOB bus (IDLE/SETUP/STROBE/WAIT/HOLD).
// Optional one-entry posted-write buffer enabled by macro IOB_POSTED_WRITE_EN.
module iob_responder
   import iob_responder_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = TimeoutCycDefault
) (
   input logic            CLK,
   input logic            RES,
   iob_responder_if.slave bus
);
   localparam logic [7:0] TimeoutVal = 8'(TIMEOUT_CYC);

   state_e    state_q;
   logic [7:0] wcnt_q;
   logic [7:0] wcnt_inc;
   logic      serviced_q;
   pw_entry_t cur_q;
   logic      cur_rnw_q;
   logic      cur_posted_q;
   logic      err_q;
   logic      dtack_s;
   logic      berr_s;
   logic      start;
   logic      post_req;
   logic      post_ack;
   logic      buf_full;
   pw_entry_t buf_entry;

   iob_sync2 u_sync_dtack (
      .CLK (CLK),
      .RES (RES),
      .d   (bus.IOnDTACK),
      .q   (dtack_s)
   );

   iob_sync2 u_sync_berr (
      .CLK (CLK),
      .RES (RES),
      .d   (bus.IOnBERR),
      .q   (berr_s)
   );

`ifdef IOB_POSTED_WRITE_EN
   logic      buf_full_q;
   pw_entry_t buf_q;
   logic      post_ack_q;

   // A drain's HOLD edge may refill the buffer directly so BUSY never dips.
   assign post_req = bus.BACT & bus.IOCS & bus.IOPWCS & ~bus.nWE & ~serviced_q &
                     (((state_q == StIdle) & ~buf_full_q) | ((state_q == StHold) & cur_posted_q));

   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         buf_full_q <= 1'b0;
         buf_q      <= '0;
         post_ack_q <= 1'b0;
      end else begin
         post_ack_q <= post_req;
         if (post_req) begin
            buf_full_q <= 1'b1;
            buf_q      <= '{addr: bus.A, data: bus.DIN, strb: {bus.nUDS, bus.nLDS}};
         end else if ((state_q == StHold) && cur_posted_q) begin
            buf_full_q <= 1'b0;
         end
      end
   end

   assign buf_full  = buf_full_q;
   assign buf_entry = buf_q;
   assign post_ack  = post_ack_q;
`else
   logic unused_iopwcs;

   assign unused_iopwcs = bus.IOPWCS;
   assign post_req      = 1'b0;
   assign post_ack      = 1'b0;
   assign buf_full      = 1'b0;
   assign buf_entry     = '0;
`endif

   assign start    = (state_q == StIdle) & ~buf_full & ~post_req & bus.BACT &
                     (bus.IOCS | bus.IACS) & ~serviced_q;
   assign wcnt_inc = sat_inc8(wcnt_q);
   assign bus.BUSY = (state_q != StIdle) | buf_full;

   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         state_q      <= StIdle;
         wcnt_q       <= '0;
         serviced_q   <= 1'b0;
         cur_q        <= '0;
         cur_rnw_q    <= 1'b1;
         cur_posted_q <= 1'b0;
         err_q        <= 1'b0;
         bus.IOA      <= '0;
         bus.IODOUT   <= '0;
         bus.DOUT     <= '0;
         bus.IOnAS    <= 1'b1;
         bus.IOnUDS   <= 1'b1;
         bus.IOnLDS   <= 1'b1;
         bus.IORnW    <= 1'b1;
         bus.FSB_ACK  <= 1'b0;
         bus.BERR     <= 1'b0;
      end else begin
         serviced_q  <= bus.BACT & (serviced_q | start | post_req);
         bus.FSB_ACK <= post_ack;
         bus.BERR    <= 1'b0;
         unique case (state_q)
            StIdle: begin
               bus.IORnW <= 1'b1;
               if (buf_full) begin
                  cur_q        <= buf_entry;
                  cur_rnw_q    <= 1'b0;
                  cur_posted_q <= 1'b1;
                  state_q      <= StSetup;
               end else if (start) begin
                  cur_q        <= '{addr: bus.A, data: bus.DIN, strb: {bus.nUDS, bus.nLDS}};
                  cur_rnw_q    <= bus.nWE | bus.IACS;
                  cur_posted_q <= 1'b0;
                  state_q      <= StSetup;
               end
            end
            StSetup: begin
               bus.IOA    <= cur_q.addr;
               bus.IORnW  <= cur_rnw_q;
               bus.IODOUT <= cur_q.data;
               state_q    <= StStrobe;
            end
            StStrobe: begin
               bus.IOnAS  <= 1'b0;
               bus.IOnUDS <= cur_q.strb[1];
               bus.IOnLDS <= cur_q.strb[0];
               wcnt_q     <= '0;
               state_q    <= StWait;
            end
            StWait: begin
               wcnt_q <= wcnt_inc;
               if (!berr_s || !dtack_s || (wcnt_inc == TimeoutVal)) begin
                  // BERR beats DTACK; neither seen means timeout.
                  err_q <= ~berr_s | dtack_s;
                  if (cur_rnw_q) begin
                     bus.DOUT <= bus.IODIN;
                  end
                  state_q <= StHold;
               end
            end
            StHold: begin
               bus.IOnAS  <= 1'b1;
               bus.IOnUDS <= 1'b1;
               bus.IOnLDS <= 1'b1;
               bus.IORnW  <= 1'b1;
               state_q    <= StIdle;
               if (!cur_posted_q && bus.BACT) begin
                  bus.FSB_ACK <= 1'b1;
                  bus.BERR    <= err_q;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end
endmodule
